core_spike_scheduler: RTL and testbench

//  Parametrised successor of the per-core axon scheduler: NUM_SLOTS-deep tick-delay ring of NUM_AXONS-bit spike vectors.

---
 rtl/core_spike_scheduler.sv | 103 ++++++++++
 tb/tb_core_spike_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/core_spike_scheduler.sv
// Per-core tick-delay ring: NUM_SLOTS slots of NUM_AXONS-bit spike vectors fed by router packets,
// with the current slot presented combinationally to the neuron grid.
module core_spike_scheduler #(
  parameter int unsigned NUM_AXONS = 256,
  parameter int unsigned NUM_SLOTS = 16,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned AXON_W   = $clog2(NUM_AXONS),
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOTS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wen,
  input  logic [SLOT_W+AXON_W-1:0] packet,
  input  logic                     set,
  input  logic                     clr,
  output logic [NUM_AXONS-1:0]     axon_spikes,
  output logic [SLOT_W-1:0]        slot_ptr,
  output logic                     error,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         dup_count
);

  logic [NUM_AXONS-1:0] slot_q [NUM_SLOTS];
  logic [SLOT_W-1:0]    slot_ptr_q, slot_ptr_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     drop_count_q, drop_count_d;
  logic [CNT_W-1:0]     dup_count_q, dup_count_d;

  logic [SLOT_W-1:0] pkt_delay;
  logic [AXON_W-1:0] pkt_axon;
  logic [SLOT_W-1:0] target;
  logic              drop;
  logic              wr_ok;
  logic              dup;

  assign pkt_delay = packet[SLOT_W+AXON_W-1:AXON_W];
  assign pkt_axon  = packet[AXON_W-1:0];

  // Power-of-two ring, so the SLOT_W-bit sum wraps modulo NUM_SLOTS for free.
  assign target = slot_ptr_q + pkt_delay + SLOT_W'(1);

  // delay == NUM_SLOTS-1 lands on the slot being presented now; reject it.
  assign drop  = wen && (pkt_delay == SLOT_W'(NUM_SLOTS - 1));
  assign wr_ok = wen && !drop;
  assign dup   = wr_ok && slot_q[target][pkt_axon];

  always_comb begin
    slot_ptr_d   = slot_ptr_q;
    error_d      = error_q;
    drop_count_d = drop_count_q;
    dup_count_d  = dup_count_q;
    if (set) begin
      slot_ptr_d = slot_ptr_q + SLOT_W'(1);
    end
    if (drop) begin
      error_d = 1'b1;
      if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + CNT_W'(1);
      end
    end
    if (dup && (dup_count_q != '1)) begin
      dup_count_d = dup_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_ptr_q   <= '0;
      error_q      <= 1'b0;
      drop_count_q <= '0;
      dup_count_q  <= '0;
    end else begin
      slot_ptr_q   <= slot_ptr_d;
      error_q      <= error_d;
      drop_count_q <= drop_count_d;
      dup_count_q  <= dup_count_d;
    end
  end

  // A valid write never targets the current slot, so clr and write cannot collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (clr && (SLOT_W'(s) == slot_ptr_q)) begin
          slot_q[s] <= '0;
        end else if (wr_ok && (SLOT_W'(s) == target)) begin
          slot_q[s][pkt_axon] <= 1'b1;
        end
      end
    end
  end

  assign axon_spikes = slot_q[slot_ptr_q];
  assign slot_ptr    = slot_ptr_q;
  assign error       = error_q;
  assign drop_count  = drop_count_q;
  assign dup_count   = dup_count_q;

endmodule

// File: tb/tb_core_spike_scheduler.sv
// Scoreboard bench for core_spike_scheduler: directed steps push expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_core_spike_scheduler;

  localparam int NA     = 256;
  localparam int NS     = 16;
  localparam int CW     = 16;
  localparam int AXON_W = 8;
  localparam int SLOT_W = 4;

  logic                     clk;
  logic                     reset_n;
  logic                     wen;
  logic [SLOT_W+AXON_W-1:0] packet;
  logic                     set;
  logic                     clr;
  logic [NA-1:0]            axon_spikes;
  logic [SLOT_W-1:0]        slot_ptr;
  logic                     error;
  logic [CW-1:0]            drop_count;
  logic [CW-1:0]            dup_count;

  core_spike_scheduler #(
    .NUM_AXONS(NA),
    .NUM_SLOTS(NS),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wen        (wen),
    .packet     (packet),
    .set        (set),
    .clr        (clr),
    .axon_spikes(axon_spikes),
    .slot_ptr   (slot_ptr),
    .error      (error),
    .drop_count (drop_count),
    .dup_count  (dup_count)
  );

  typedef struct {
    logic [NA-1:0] spikes;
    int            ptr;
    logic          err;
    int            drops;
    int            dups;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    passed = 0;
  int    total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares every queued expectation against the settled DUT outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (axon_spikes === e.spikes && int'(slot_ptr) == e.ptr && error === e.err &&
          int'(drop_count) == e.drops && int'(dup_count) == e.dups) begin
        passed++;
      end else begin
        $display("FAIL %s: got spikes=%h ptr=%0d err=%0b drop=%0d dup=%0d; want spikes=%h ptr=%0d err=%0b drop=%0d dup=%0d",
                 n, axon_spikes, slot_ptr, error, drop_count, dup_count,
                 e.spikes, e.ptr, e.err, e.drops, e.dups);
      end
    end
  end

  function automatic logic [NA-1:0] onehot(input int i);
    logic [NA-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic step(input logic w, input int d, input int a, input logic s, input logic c);
    wen    = w;
    packet = {SLOT_W'(d), AXON_W'(a)};
    set    = s;
    clr    = c;
    @(posedge clk);
    #1;
    wen = 1'b0;
    set = 1'b0;
    clr = 1'b0;
  endtask

  task automatic sets(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic expect_out(input string n, input logic [NA-1:0] sp, input int p, input logic er,
                            input int dr, input int du);
    exp_t e;
    e.spikes = sp;
    e.ptr    = p;
    e.err    = er;
    e.drops  = dr;
    e.dups   = du;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wen     = 1'b0;
    packet  = '0;
    set     = 1'b0;
    clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    expect_out("reset", '0, 0, 1'b0, 0, 0);

    // delay 0 -> slot 1
    step(1'b1, 0, 5, 1'b0, 1'b0);
    expect_out("d0_before_set", '0, 0, 1'b0, 0, 0);
    sets(1);
    expect_out("d0_after_set", onehot(5), 1, 1'b0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    expect_out("d0_clr", '0, 1, 1'b0, 0, 0);

    // delay 3 from ptr 1 -> slot 5
    step(1'b1, 3, 255, 1'b0, 1'b0);
    sets(3);
    expect_out("d3_three_sets", '0, 4, 1'b0, 0, 0);
    sets(1);
    expect_out("d3_four_sets", onehot(255), 5, 1'b0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    expect_out("d3_clr", '0, 5, 1'b0, 0, 0);
    sets(16);
    expect_out("d3_no_ghost", '0, 5, 1'b0, 0, 0);

    // wrap: ptr 15, delay 14 -> slot 14
    sets(10);
    expect_out("wrap_ptr15", '0, 15, 1'b0, 0, 0);
    step(1'b1, 14, 7, 1'b0, 1'b0);
    sets(14);
    expect_out("wrap_14_sets", '0, 13, 1'b0, 0, 0);
    sets(1);
    expect_out("wrap_15_sets", onehot(7), 14, 1'b0, 0, 0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    expect_out("wrap_clr", '0, 14, 1'b0, 0, 0);

    // alias delay is dropped; sweep every slot
    step(1'b1, 15, 9, 1'b0, 1'b0);
    expect_out("drop_flag", '0, 14, 1'b1, 1, 0);
    for (int i = 1; i <= NS; i++) begin
      sets(1);
      expect_out($sformatf("drop_sweep_%0d", i), '0, (14 + i) % NS, 1'b1, 1, 0);
    end

    // duplicate write, ptr 14 -> slot 15
    step(1'b1, 0, 3, 1'b0, 1'b0);
    expect_out("dup_first", '0, 14, 1'b1, 1, 0);
    step(1'b1, 0, 3, 1'b0, 1'b0);
    expect_out("dup_second", '0, 14, 1'b1, 1, 1);
    sets(1);
    expect_out("dup_visible", onehot(3), 15, 1'b1, 1, 1);

    // wen+set+clr at ptr 15: slot 15 cleared, spike lands in slot 0
    step(1'b1, 0, 1, 1'b1, 1'b1);
    expect_out("combo_new_slot", onehot(1), 0, 1'b1, 1, 1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    sets(15);
    expect_out("combo_old_cleared", '0, 15, 1'b1, 1, 1);

    // async reset mid-ring with a spike pending for slot 2
    step(1'b1, 2, 4, 1'b0, 1'b0);
    sets(1);
    expect_out("pre_reset", '0, 0, 1'b1, 1, 1);
    reset_n = 1'b0;
    expect_out("async_reset", '0, 0, 1'b0, 0, 0);
    reset_n = 1'b1;
    sets(2);
    expect_out("reset_discard", '0, 2, 1'b0, 0, 0);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard: got %0d unchecked expectations, want 0", exp_q.size());
    end
    if (passed == total && total > 0) begin
      $display("PASS %0d/%0d checks passed", passed, total);
    end else begin
      $display("FAIL %0d/%0d checks passed", passed, total);
    end
    $finish;
  end

endmodule
